dff_mem_arbiter: RTL and testbench

DFF_MEM_ARBITER -- requirements
Module: dff_mem_arbiter

---
 rtl/dff_mem_arbiter_pkg.sv | 27 ++
 rtl/dff_mem_arbiter_rr_arb2.sv | 24 ++
 rtl/dff_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_dff_mem_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   - default address/data widths
//   - FSM state encoding
//   - requester ID encoding (A=0, B=1) and a one-hot helper
package dff_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // One-hot position of a requester: bit 0 = A, bit 1 = B.
  function automatic logic [1:0] id_onehot(input req_id_e id);
    return (id == REQ_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dff_mem_arbiter_rr_arb2.sv
// Two-way round-robin selector.
//   req_i        : request vector, bit 0 = A, bit 1 = B
//   last_grant_i : requester ID that won the most recent handshake
//   gnt_o        : one-hot grant (all zero when nothing requests)
// With a single requester it wins outright; under contention the
// requester that did not win last time is chosen.
module rr_arb2
  import dff_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i == 2'b11) begin
      gnt_o = (last_grant_i == REQ_A) ? id_onehot(REQ_B) : id_onehot(REQ_A);
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/dff_mem_arbiter.sv
// Sequences single-outstanding memory transactions from two requesters
// (A and B) onto one external registered memory.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ena                 : when low, no new grants (in-flight work finishes)
//   a_*/b_*             : per-requester valid/ready/we/addr/wdata and rsp pulse
//   rsp_rdata           : read data, held until the next completed read
//   mem_en/we/addr/wdata: memory command, strobed for one cycle in ISSUE
//   mem_rdata           : memory read data, valid the cycle after a read strobe
//   busy                : high whenever the FSM is not in IDLE
// Latency from handshake cycle T: write rsp at T+2, read rsp at T+3.
module dff_mem_arbiter
  import dff_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              a_valid,
  input  logic              b_valid,
  output logic              a_ready,
  output logic              b_ready,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_rsp,
  output logic              b_rsp,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e              state_q;
  req_id_e             owner_q;
  req_id_e             last_grant_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                a_rsp_q;
  logic                b_rsp_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                busy_q;

  logic [1:0]          gnt;
  logic                can_grant;

  rr_arb2 u_rr_arb2 (
    .req_i        ({b_valid, a_valid}),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  // Ready is only offered from IDLE with ena high; rst masks it so nothing
  // can be accepted in the same cycle reset is being applied.
  assign can_grant = (state_q == ST_IDLE) && ena && !rst;
  assign a_ready   = can_grant && gnt[0];
  assign b_ready   = can_grant && gnt[1];

  // The mem_* command registers double as the latched request: they are
  // loaded on the handshake and therefore present during ISSUE. mem_we_q
  // stays valid through ISSUE so it also steers the write/read branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_A;
      last_grant_q <= REQ_B;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      a_rsp_q      <= 1'b0;
      b_rsp_q      <= 1'b0;
      rsp_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          a_rsp_q <= 1'b0;
          b_rsp_q <= 1'b0;
          if (a_ready || b_ready) begin
            owner_q      <= b_ready ? REQ_B : REQ_A;
            last_grant_q <= b_ready ? REQ_B : REQ_A;
            mem_en_q     <= 1'b1;
            mem_we_q     <= b_ready ? b_we    : a_we;
            mem_addr_q   <= b_ready ? b_addr  : a_addr;
            mem_wdata_q  <= b_ready ? b_wdata : a_wdata;
            busy_q       <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_en_q <= 1'b0;
          if (mem_we_q) begin
            a_rsp_q <= (owner_q == REQ_A);
            b_rsp_q <= (owner_q == REQ_B);
            state_q <= ST_RESP;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          rsp_rdata_q <= mem_rdata;
          a_rsp_q     <= (owner_q == REQ_A);
          b_rsp_q     <= (owner_q == REQ_B);
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          a_rsp_q <= 1'b0;
          b_rsp_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign a_rsp     = a_rsp_q;
  assign b_rsp     = b_rsp_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dff_mem_arbiter.sv
module tb_dff_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic          a_we = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_rsp, b_rsp;
  logic [DW-1:0] rsp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic          owner;  // 0 = A, 1 = B
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sbq[$];
  exp_t          e;
  logic [1:0]    exp_oh;
  logic [DW-1:0] ref_mem [16] = '{default: '0};
  logic [DW-1:0] mem     [16] = '{default: '0};

  dff_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .a_valid(a_valid), .b_valid(b_valid),
    .a_ready(a_ready), .b_ready(b_ready),
    .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr),
    .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_rsp(a_rsp), .b_rsp(b_rsp),
    .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // External registered memory
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Scoreboard: every rsp pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (a_ready || b_ready) begin
      n_vec++;
      if (a_ready && b_ready) begin
        n_bad++;
        $display("FAIL ready_onehot: a_ready=%0b b_ready=%0b, want at most one", a_ready, b_ready);
      end
    end
    if (a_rsp || b_rsp) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rsp: a_rsp=%0b b_rsp=%0b, want no pulse", a_rsp, b_rsp);
      end else begin
        e = sbq.pop_front();
        exp_oh = e.owner ? 2'b10 : 2'b01;
        if ({b_rsp, a_rsp} !== exp_oh) begin
          n_bad++;
          $display("FAIL sb_owner: {b_rsp,a_rsp}=%b, want %b", {b_rsp, a_rsp}, exp_oh);
        end
        if (e.rd && (rsp_rdata !== e.data)) begin
          n_bad++;
          $display("FAIL sb_rdata: rsp_rdata=%h, want %h", rsp_rdata, e.data);
        end
      end
    end
  end

  task automatic set_req(input logic who, input logic v, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] d);
    if (who) begin b_valid = v; b_we = we; b_addr = addr; b_wdata = d; end
    else     begin a_valid = v; a_we = we; a_addr = addr; a_wdata = d; end
  endtask

  task automatic push_exp(input logic who, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] d);
    sbq.push_back('{owner: who, rd: !we, data: (we ? d : ref_mem[addr])});
    if (we) ref_mem[addr] = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
  endtask

  // Full transaction with bounded waits; response checked by the scoreboard
  task automatic run_req(input logic who, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] d);
    bit got;
    @(posedge clk); #1;
    set_req(who, 1'b1, we, addr, d);
    #1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (who ? b_ready : a_ready) begin got = 1; break; end
      @(posedge clk); #2;
    end
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL hs_timeout: ready=0 after 20 cycles, want 1");
      set_req(who, 1'b0, 1'b0, '0, '0);
      return;
    end
    push_exp(who, we, addr, d);
    @(posedge clk); #1;
    set_req(who, 1'b0, 1'b0, '0, '0);
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_rsp || b_rsp) begin got = 1; break; end
    end
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL rsp_timeout: no rsp after 10 cycles, want pulse");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; ena = 1'b1;
    #1;
    n_vec++;
    if ({a_ready, b_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ready: {a,b}_ready=%b, want 00", {a_ready, b_ready});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({a_rsp, b_rsp, mem_en, mem_we, busy, mem_addr, mem_wdata, rsp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rsp=%b mem_en=%b busy=%b rdata=%h, want all 0",
               {a_rsp, b_rsp}, mem_en, busy, rsp_rdata);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;
    sbq.delete();
  endtask

  task automatic test_single_write();
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, 4'd3, 8'h5A);
    #1;
    n_vec++;
    if ({b_ready, a_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL wr_ready_T: {b,a}_ready=%b, want 01", {b_ready, a_ready});
    end
    push_exp(1'b0, 1'b1, 4'd3, 8'h5A);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    n_vec++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, a_rsp} !== {1'b1, 1'b1, 4'd3, 8'h5A, 1'b0}) begin
      n_bad++;
      $display("FAIL wr_cmd_T1: en=%b we=%b addr=%h wdata=%h a_rsp=%b, want 1 1 3 5a 0",
               mem_en, mem_we, mem_addr, mem_wdata, a_rsp);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({a_rsp, b_rsp, mem_en} !== 3'b100) begin
      n_bad++;
      $display("FAIL wr_rsp_T2: a_rsp=%b b_rsp=%b mem_en=%b, want 1 0 0", a_rsp, b_rsp, mem_en);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({a_rsp, b_rsp, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL wr_done_T3: a_rsp=%b b_rsp=%b busy=%b, want 0 0 0", a_rsp, b_rsp, busy);
    end
  endtask

  task automatic test_read_back();
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 1'b0, 4'd3, '0);
    #1;
    n_vec++;
    if ({b_ready, a_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL rd_ready_T: {b,a}_ready=%b, want 10", {b_ready, a_ready});
    end
    push_exp(1'b1, 1'b0, 4'd3, '0);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    n_vec++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 4'd3}) begin
      n_bad++;
      $display("FAIL rd_cmd_T1: en=%b we=%b addr=%h, want 1 0 3", mem_en, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({a_rsp, b_rsp, mem_en, busy} !== 4'b0001) begin
      n_bad++;
      $display("FAIL rd_wait_T2: rsp=%b mem_en=%b busy=%b, want 00 0 1", {a_rsp, b_rsp}, mem_en, busy);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({b_rsp, a_rsp, rsp_rdata} !== {2'b10, 8'h5A}) begin
      n_bad++;
      $display("FAIL rd_rsp_T3: {b,a}_rsp=%b rdata=%h, want 10 5a", {b_rsp, a_rsp}, rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int hs;
    logic [1:0] want;
    do_reset();
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, 4'd5, 8'hA5);
    set_req(1'b1, 1'b1, 1'b1, 4'd6, 8'hB6);
    hs = 0;
    for (int c = 0; c < 60 && hs < 4; c++) begin
      @(negedge clk);
      if (a_ready || b_ready) begin
        want = (hs % 2 == 0) ? 2'b01 : 2'b10;
        n_vec++;
        if ({b_ready, a_ready} !== want) begin
          n_bad++;
          $display("FAIL rr_grant%0d: {b,a}_ready=%b, want %b", hs, {b_ready, a_ready}, want);
        end
        if (a_ready) push_exp(1'b0, 1'b1, 4'd5, 8'hA5);
        else         push_exp(1'b1, 1'b1, 4'd6, 8'hB6);
        hs++;
        if (hs == 4) begin
          @(posedge clk); #1;
          a_valid = 1'b0; b_valid = 1'b0;
        end
      end
    end
    n_vec++;
    if (hs != 4) begin
      n_bad++;
      $display("FAIL rr_count: handshakes=%0d, want 4", hs);
      a_valid = 1'b0; b_valid = 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0) break;
    end
    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL rr_drain: %0d responses outstanding, want 0", sbq.size());
    end
    run_req(1'b0, 1'b0, 4'd6, '0);
  endtask

  task automatic test_enable_gating();
    bit got;
    @(posedge clk); #1;
    ena = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 4'd3, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (a_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL ena_block%0d: a_ready=%b, want 0", i, a_ready);
      end
    end
    @(posedge clk); #1;
    ena = 1'b1;
    #1;
    n_vec++;
    if (a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ena_release: a_ready=%b, want 1", a_ready);
    end
    push_exp(1'b0, 1'b0, 4'd3, '0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    ena = 1'b0;  // must not stall the in-flight read
    got = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (a_rsp) begin got = 1; break; end
    end
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL ena_midtxn: a_rsp=0 within 5 cycles, want pulse");
    end
    @(posedge clk); #1;
    ena = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 4'd3, '0);
    #1;
    n_vec++;
    if (a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rmr_ready: a_ready=%b, want 1", a_ready);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;   // WAIT cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if ({busy, a_rsp, b_rsp, mem_en, rsp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL rmr_abort: busy=%b rsp=%b mem_en=%b rdata=%h, want 0 00 0 00",
               busy, {a_rsp, b_rsp}, mem_en, rsp_rdata);
    end
    sbq.delete();
    run_req(1'b1, 1'b0, 4'd3, '0);
    n_vec++;
    if (rsp_rdata !== 8'h5A) begin
      n_bad++;
      $display("FAIL rmr_after: rsp_rdata=%h, want 5a", rsp_rdata);
    end
  endtask

  task automatic test_boundary();
    run_req(1'b0, 1'b1, 4'd15, 8'hFF);
    n_vec++;
    if (rsp_rdata !== 8'h5A) begin
      n_bad++;
      $display("FAIL hold_rdata: rsp_rdata=%h, want 5a", rsp_rdata);
    end
    run_req(1'b1, 1'b0, 4'd15, '0);
    n_vec++;
    if (rsp_rdata !== 8'hFF) begin
      n_bad++;
      $display("FAIL addr15_rd: rsp_rdata=%h, want ff", rsp_rdata);
    end
    run_req(1'b0, 1'b0, 4'd0, '0);
    n_vec++;
    if (rsp_rdata !== 8'h00) begin
      n_bad++;
      $display("FAIL addr0_rd: rsp_rdata=%h, want 00", rsp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_contention();
    test_enable_gating();
    test_reset_mid_read();
    test_boundary();
    repeat (3) @(posedge clk);
    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL final_drain: %0d responses outstanding, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
